// File: rtl/din_debounce_pulse.sv
// Synchronizes and debounces a bouncy raw input into a clean level and a one-cycle press pulse.
// Define DEBOUNCE_REL_PULSE_EN to add the rel_pulse output, which pulses on each accepted release.
module din_debounce_pulse #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_in,
    output logic level,
    output logic press_pulse
`ifdef DEBOUNCE_REL_PULSE_EN
    ,
    output logic rel_pulse
`endif
);

    localparam logic [1:0] LOW      = 2'd0;
    localparam logic [1:0] RISE_CHK = 2'd1;
    localparam logic [1:0] HIGH     = 2'd2;
    localparam logic [1:0] FALL_CHK = 2'd3;

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    logic [1:0]             state;
    logic [CNT_W-1:0]       cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw_in};
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    // cnt holds how many consecutive samples have disagreed with the accepted level.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= LOW;
            cnt         <= '0;
            level       <= 1'b0;
            press_pulse <= 1'b0;
`ifdef DEBOUNCE_REL_PULSE_EN
            rel_pulse   <= 1'b0;
`endif
        end else begin
            press_pulse <= 1'b0;
`ifdef DEBOUNCE_REL_PULSE_EN
            rel_pulse   <= 1'b0;
`endif
            case (state)
                LOW: begin
                    if (s) begin
                        state <= RISE_CHK;
                        cnt   <= CNT_ONE;
                    end else begin
                        cnt   <= '0;
                    end
                end
                RISE_CHK: begin
                    if (!s) begin
                        state <= LOW;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state       <= HIGH;
                        level       <= 1'b1;
                        press_pulse <= 1'b1;
                        cnt         <= '0;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                HIGH: begin
                    if (!s) begin
                        state <= FALL_CHK;
                        cnt   <= CNT_ONE;
                    end else begin
                        cnt   <= '0;
                    end
                end
                FALL_CHK: begin
                    if (s) begin
                        state <= HIGH;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state <= LOW;
                        level <= 1'b0;
                        cnt   <= '0;
`ifdef DEBOUNCE_REL_PULSE_EN
                        rel_pulse <= 1'b1;
`else
                        // Without the release pulse only level reports the release.
`endif
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                default: begin
                    state <= LOW;
                    cnt   <= '0;
                    level <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_din_debounce_pulse.sv
// Self-checking bench for din_debounce_pulse: directed vectors plus a per-cycle run-length model.
// Honours DEBOUNCE_REL_PULSE_EN for the optional rel_pulse output.
module tb_din_debounce_pulse;

    localparam int SYNC_STAGES     = 2;
    localparam int DEBOUNCE_CYCLES = 4;
    localparam int CNT_W           = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic raw_in = 1'b0;
    logic level;
    logic press_pulse;
`ifdef DEBOUNCE_REL_PULSE_EN
    logic rel_pulse;
    int   rel_first;
    int   rel_count;
`endif

    int checks = 0;
    int errors = 0;

    din_debounce_pulse #(
        .SYNC_STAGES(SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .raw_in(raw_in),
        .level(level),
        .press_pulse(press_pulse)
`ifdef DEBOUNCE_REL_PULSE_EN
        ,
        .rel_pulse(rel_pulse)
`endif
    );

    always #5 clk = ~clk;

    // Model: raw_in reaches the decision logic SYNC_STAGES edges late; the level flips once
    // DEBOUNCE_CYCLES consecutive delayed samples disagree with it.
    logic                   model_valid = 1'b0;
    logic [SYNC_STAGES-1:0] m_delay;
    logic                   m_level;
    logic                   m_press;
    logic                   m_rel;
    int                     m_run;

    always @(posedge clk) begin
        if (rst) begin
            m_delay     = '0;
            m_level     = 1'b0;
            m_press     = 1'b0;
            m_rel       = 1'b0;
            m_run       = 0;
            model_valid = 1'b1;
        end else begin
            m_press = 1'b0;
            m_rel   = 1'b0;
            if (m_delay[SYNC_STAGES-1] != m_level) m_run = m_run + 1;
            else m_run = 0;
            if (m_run == DEBOUNCE_CYCLES) begin
                m_level = ~m_level;
                if (m_level) m_press = 1'b1;
                else m_rel = 1'b1;
                m_run = 0;
            end
            m_delay = {m_delay[SYNC_STAGES-2:0], raw_in};
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    always @(negedge clk) begin
        if (model_valid) begin
            checkOutput("model_level", {31'd0, level}, {31'd0, m_level});
            checkOutput("model_press", {31'd0, press_pulse}, {31'd0, m_press});
`ifdef DEBOUNCE_REL_PULSE_EN
            checkOutput("model_rel", {31'd0, rel_pulse}, {31'd0, m_rel});
`endif
        end
    end

    // Holds raw_in at val for n cycles, reporting where pulses and the level flip appear
    // (1-based negedge index after the drive; 0 means never).
    task automatic applyStimulus(input logic val, input int n, output int first_press,
                                 output int n_press, output int first_flip,
                                 output logic last_level);
        logic start_level;
        start_level = level;
        first_press = 0;
        n_press     = 0;
        first_flip  = 0;
`ifdef DEBOUNCE_REL_PULSE_EN
        rel_first = 0;
        rel_count = 0;
`endif
        raw_in = val;
        for (int i = 1; i <= n; i++) begin
            @(negedge clk);
            if (press_pulse === 1'b1) begin
                n_press++;
                if (first_press == 0) first_press = i;
            end
            if (first_flip == 0 && level !== start_level) first_flip = i;
`ifdef DEBOUNCE_REL_PULSE_EN
            if (rel_pulse === 1'b1) begin
                rel_count++;
                if (rel_first == 0) rel_first = i;
            end
`endif
        end
        last_level = level;
    endtask

    initial begin
        int   fp;
        int   np;
        int   ff;
        int   bounce_presses;
        logic lv;

        rst    = 1'b1;
        raw_in = 1'b1;
        repeat (5) begin
            @(negedge clk);
            checkOutput("reset_level", {31'd0, level}, 32'd0);
            checkOutput("reset_press", {31'd0, press_pulse}, 32'd0);
        end

        $display("[TB] reset release with raw_in held high");
        rst = 1'b0;
        applyStimulus(1'b1, 10, fp, np, ff, lv);
        checkOutput("por_first_press", fp, 6);
        checkOutput("por_press_count", np, 1);
        checkOutput("por_level", {31'd0, lv}, 32'd1);

        $display("[TB] release then clean press held 20 cycles");
        applyStimulus(1'b0, 10, fp, np, ff, lv);
        checkOutput("release_level", {31'd0, lv}, 32'd0);
        checkOutput("release_press_count", np, 0);
        checkOutput("release_flip", ff, 6);
`ifdef DEBOUNCE_REL_PULSE_EN
        checkOutput("release_rel_first", rel_first, 6);
        checkOutput("release_rel_count", rel_count, 1);
`endif
        applyStimulus(1'b1, 20, fp, np, ff, lv);
        checkOutput("hold_first_press", fp, 6);
        checkOutput("hold_press_count", np, 1);
        checkOutput("hold_level", {31'd0, lv}, 32'd1);

        $display("[TB] short 3-cycle glitch");
        applyStimulus(1'b0, 10, fp, np, ff, lv);
        checkOutput("pre_glitch_level", {31'd0, lv}, 32'd0);
        applyStimulus(1'b1, 3, fp, np, ff, lv);
        checkOutput("glitch_press_count", np, 0);
        applyStimulus(1'b0, 10, fp, np, ff, lv);
        checkOutput("glitch_tail_press_count", np, 0);
        checkOutput("glitch_level", {31'd0, lv}, 32'd0);

        $display("[TB] bounce 1,0,1,0,1 then hold");
        bounce_presses = 0;
        applyStimulus(1'b1, 1, fp, np, ff, lv);
        bounce_presses += np;
        applyStimulus(1'b0, 1, fp, np, ff, lv);
        bounce_presses += np;
        applyStimulus(1'b1, 1, fp, np, ff, lv);
        bounce_presses += np;
        applyStimulus(1'b0, 1, fp, np, ff, lv);
        bounce_presses += np;
        checkOutput("bounce_early_presses", bounce_presses, 0);
        applyStimulus(1'b1, 15, fp, np, ff, lv);
        checkOutput("bounce_first_press", fp, 6);
        checkOutput("bounce_press_count", np, 1);
        checkOutput("bounce_level", {31'd0, lv}, 32'd1);

        $display("[TB] release from HIGH");
        applyStimulus(1'b0, 15, fp, np, ff, lv);
        checkOutput("fall_flip", ff, 6);
        checkOutput("fall_press_count", np, 0);
        checkOutput("fall_level", {31'd0, lv}, 32'd0);
`ifdef DEBOUNCE_REL_PULSE_EN
        checkOutput("fall_rel_first", rel_first, 6);
        checkOutput("fall_rel_count", rel_count, 1);
`endif

        $display("[TB] reset in the middle of a rise check");
        applyStimulus(1'b1, 4, fp, np, ff, lv);
        checkOutput("midchk_press_count", np, 0);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("midchk_reset_press", {31'd0, press_pulse}, 32'd0);
        checkOutput("midchk_reset_level", {31'd0, level}, 32'd0);
        rst = 1'b0;
        applyStimulus(1'b1, 12, fp, np, ff, lv);
        checkOutput("midchk_first_press", fp, 6);
        checkOutput("midchk_press_count", np, 1);
        checkOutput("midchk_level", {31'd0, lv}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/din_debounce_pulse.md
Name: din_debounce_pulse

Overview:
- Upstream input conditioner for the team's Moore toggle FSM.
- Takes an asynchronous, bouncy raw input (push-button or external strobe), synchronizes it to clk, and debounces it with a stability counter.
- Emits a clean debounced level plus a single-cycle press pulse; press_pulse drives the FSM's din, so each physical press advances the FSM exactly once.

Parameters:
- SYNC_STAGES, 2, number of synchronizer flops on raw_in; legal 2..4.
- DEBOUNCE_CYCLES, 4, consecutive stable synchronized samples required to accept a transition; legal 2..(2^CNT_W - 1).
- CNT_W, 8, stability counter width.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  reset.
- raw_in  input  1  asynchronous raw input; may glitch or bounce.
- level  output  1  debounced level of raw_in.
- press_pulse  output  1  one-cycle high pulse on each accepted 0->1 transition.
- rel_pulse  output  1  one-cycle high pulse on each accepted 1->0 transition; exists only with DEBOUNCE_REL_PULSE_EN.

Behaviour:
- Reset: rst is synchronous and active-high; clock is clk. While rst=1 at a clk edge:
  - all synchronizer flops clear to 0;
  - state goes to LOW and cnt to 0;
  - level, press_pulse and rel_pulse register to 0.
  - Reset overrides every other condition, including mid-check and mid-pulse.
- Synchronizer: a chain of SYNC_STAGES flops; s is the last stage. The FSM and counter use only s, never raw_in.
- FSM: 4 states, all outputs registered.
  - LOW (level=0): if s=1, go to RISE_CHK with cnt<=1; else stay with cnt<=0.
  - RISE_CHK (level=0):
    - if s=0, go back to LOW with cnt<=0 (glitch rejected, no pulse);
    - else if cnt==DEBOUNCE_CYCLES-1, go to HIGH, set level<=1 and press_pulse<=1, cnt<=0;
    - else cnt<=cnt+1.
  - HIGH (level=1): if s=0, go to FALL_CHK with cnt<=1; else stay.
  - FALL_CHK (level=1):
    - if s=1, go back to HIGH with cnt<=0 (no pulse);
    - else if cnt==DEBOUNCE_CYCLES-1, go to LOW, set level<=0 and rel_pulse<=1 (macro), cnt<=0;
    - else cnt<=cnt+1.
- Pulses: press_pulse and rel_pulse default to 0 every cycle and are high for exactly one cycle per accepted edge. The two pulses are never high together.
- Latency: raw_in goes high and stays stable before edge E1. level rises, and press_pulse is high, in the cycle after edge E(SYNC_STAGES+DEBOUNCE_CYCLES). With defaults that is after E6. Release latency is identical.
- Bounce: any s mismatch during a CHK state restarts the count. An accepted edge needs DEBOUNCE_CYCLES consecutive equal samples of s.
- Counter: the counter never exceeds DEBOUNCE_CYCLES-1 and never wraps.
- Reset release with raw_in held high: the synchronizer starts at 0, so this is treated as a fresh press. press_pulse fires after the full latency; that pulse is required behaviour, not a spurious one.
- Minimum press spacing: a new press_pulse requires an accepted release first. Holding raw_in high yields exactly one pulse.

Optional Feature:
- Macro: DEBOUNCE_REL_PULSE_EN.
- Defined: the rel_pulse port exists and pulses one cycle on entry to LOW from FALL_CHK.
- Undefined: the rel_pulse port and its register are absent. The FALL_CHK->LOW transition still updates level.

Test Plan (SYNC_STAGES=2, DEBOUNCE_CYCLES=4):
- Hold rst=1 with raw_in=1 for 5 cycles -> level=0 and press_pulse=0 throughout. Release rst -> press_pulse high for exactly 1 cycle after the 6th edge following release; level=1 from then on.
- raw_in 0->1, held 20 cycles -> exactly one press_pulse, 6 edges after the rise; level stays 1; no second pulse.
- raw_in high for 3 cycles, then low -> no press_pulse; level stays 0; FSM returns to LOW.
- Bounce pattern 1,0,1,0,1 (one cycle each), then hold 1 -> exactly one press_pulse, 6 edges after the final rise.
- From HIGH, drive raw_in low and hold -> level=0 after 6 edges; no press_pulse. With DEBOUNCE_REL_PULSE_EN, rel_pulse is high for 1 cycle at that point.
- Assert rst while in RISE_CHK (cnt=2) for 1 cycle, with raw_in held 1 -> no pulse during or at the reset cycle. After release, a full 6-edge latency applies before press_pulse.
